hc_sr04_multi_core: RTL

Parametrised N-channel HC-SR04 ranging core on the standard MMIO slot bus (cs/read/write/addr/wr_data/rd_data).
- Fires trigger pulses to enabled sensors in round-robin order, one sensor at a time, to avoid acoustic crosstalk.
- Times each echo in clock cycles and flags no-echo and overlong-echo timeouts.
- Supports one-shot sweeps and continuous sweeping.
- Successor to the single-channel hc_sr04 core: adds channels, a channel mask, timeouts, holdoff and continuous mode.

---
 rtl/hc_sr04_pkg.sv | 42 ++++
 rtl/hc_sr04_echo_sync.sv | 41 ++++
 rtl/hc_sr04_multi_core.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hc_sr04_pkg.sv
// Shared constants for the multi-channel HC-SR04 ranging core.
package hc_sr04_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_HOLDOFF   = 3'd4;

  // Register addresses
  localparam logic [4:0] ADDR_CTRL      = 5'd0;
  localparam logic [4:0] ADDR_STATUS    = 5'd1;
  localparam logic [4:0] ADDR_DIST_BASE = 5'd2;

  // CTRL bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_MASK_LSB  = 8;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_CH_LSB    = 1;
  localparam int STAT_VALID_LSB = 8;
  localparam int STAT_TMO_LSB   = 16;

  // Lowest set bit of m at or above index 'from'; result is {found, index}.
  function automatic logic [3:0] first_set_from(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // One-hot decode of a channel index.
  function automatic logic [7:0] ch_onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/hc_sr04_echo_sync.sv
// N-wide two-flop echo synchroniser with registered edge pulses.
// o_level is delayed one extra flop so that o_rise/o_fall line up with it.
module hc_sr04_echo_sync #(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] i_echo,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall
);

  logic [N_CH-1:0] r_meta;
  logic [N_CH-1:0] r_sync;
  logic [N_CH-1:0] r_sync_d;
  logic [N_CH-1:0] r_rise;
  logic [N_CH-1:0] r_fall;

  // Synchronise the asynchronous echoes and register their edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_sync_d <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
    end else begin
      r_meta   <= i_echo;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_rise   <= r_sync & ~r_sync_d;
      r_fall   <= ~r_sync & r_sync_d;
    end
  end

  assign o_level = r_sync_d;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/hc_sr04_multi_core.sv
// Round-robin N-channel HC-SR04 ranging core on the MMIO slot bus.
// One sensor is triggered at a time; each echo is timed in clock cycles.
module hc_sr04_multi_core
  import hc_sr04_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int TRIG_CYC    = 1000,
  parameter int RISE_TO_CYC = 3_000_000,
  parameter int ECHO_TO_CYC = 4_000_000,
  parameter int HOLDOFF_CYC = 6_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  output logic [N_CH-1:0] trigger,
  input  logic [N_CH-1:0] echo
);

  localparam logic [31:0]      TRIG_LAST    = 32'(TRIG_CYC - 1);
  localparam logic [31:0]      RISE_LIMIT   = 32'(RISE_TO_CYC);
  localparam logic [31:0]      HOLDOFF_LAST = 32'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] ECHO_LIMIT   = CNT_W'(ECHO_TO_CYC);

  logic                r_cont;
  logic [N_CH-1:0]     r_mask;
  logic [2:0]          r_state;
  logic [2:0]          r_ch;
  logic [31:0]         r_timer;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_dist [N_CH];
  logic [N_CH-1:0]     r_valid;
  logic [N_CH-1:0]     r_tmo;
  logic [N_CH-1:0]     r_trigger;

  logic                w_ctrl_wr;
  logic                w_stat_wr;
  logic                w_start;
  logic [3:0]          w_start_pick;
  logic [3:0]          w_next_pick;
  logic [3:0]          w_wrap_pick;
  logic [3:0]          w_go_pick;
  logic [7:0]          w_go_oh8;
  logic [7:0]          w_ch_oh8;
  logic [N_CH-1:0]     w_go_oh;
  logic [N_CH-1:0]     w_ch_oh;
  logic [N_CH-1:0]     w_level;
  logic [N_CH-1:0]     w_rise;
  logic [N_CH-1:0]     w_fall;
  logic                w_level_ch;
  logic                w_rise_ch;
  logic                w_fall_ch;
  logic [N_CH-1:0]     w_valid_kept;
  logic [N_CH-1:0]     w_tmo_kept;
  logic [31:0]         w_dist_ext [N_CH];
  logic                w_unused_bits;

  hc_sr04_echo_sync #(.N_CH(N_CH)) u_echo_sync (
    .clk     (clk),
    .reset   (reset),
    .i_echo  (echo),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_ctrl_wr = cs && write && (addr == ADDR_CTRL);
  assign w_stat_wr = cs && write && (addr == ADDR_STATUS);
  assign w_start   = w_ctrl_wr && wr_data[CTRL_START_BIT];

  // A START write also writes MASK, so the first channel comes from the write data.
  assign w_start_pick = first_set_from(8'(wr_data[CTRL_MASK_LSB +: N_CH]), 4'd0);
  assign w_next_pick  = first_set_from(8'(r_mask), {1'b0, r_ch} + 4'd1);
  assign w_wrap_pick  = first_set_from(8'(r_mask), 4'd0);

  // Choose the channel to launch next (found flag in bit 3)
  always_comb begin
    w_go_pick = 4'b0;
    if (r_state == ST_IDLE) w_go_pick = w_start_pick;
    else if (w_next_pick[3]) w_go_pick = w_next_pick;
    else if (r_cont)         w_go_pick = w_wrap_pick;
  end

  assign w_go_oh8   = ch_onehot(w_go_pick[2:0]);
  assign w_go_oh    = w_go_oh8[N_CH-1:0];
  assign w_ch_oh8   = ch_onehot(r_ch);
  assign w_ch_oh    = w_ch_oh8[N_CH-1:0];
  assign w_level_ch = |(w_level & w_ch_oh);
  assign w_rise_ch  = |(w_rise & w_ch_oh);
  assign w_fall_ch  = |(w_fall & w_ch_oh);

  // W1C clears; hardware sets below are applied afterwards so they win.
  assign w_valid_kept = r_valid & ~(w_stat_wr ? wr_data[STAT_VALID_LSB +: N_CH] : '0);
  assign w_tmo_kept   = r_tmo   & ~(w_stat_wr ? wr_data[STAT_TMO_LSB +: N_CH]   : '0);

  // CTRL register: CONT and MASK are stored, START is a pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cont <= 1'b0;
      r_mask <= '0;
    end else if (w_ctrl_wr) begin
      r_cont <= wr_data[CTRL_CONT_BIT];
      r_mask <= wr_data[CTRL_MASK_LSB +: N_CH];
    end
  end

  // Channel sequencer, echo timing and result/status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_ch      <= 3'd0;
      r_timer   <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_tmo     <= '0;
      r_trigger <= '0;
      for (int i = 0; i < N_CH; i++) r_dist[i] <= '0;
    end else begin
      r_valid <= w_valid_kept;
      r_tmo   <= w_tmo_kept;
      case (r_state)
        ST_IDLE: begin
          if (w_start && w_go_pick[3]) begin
            r_state   <= ST_TRIG;
            r_ch      <= w_go_pick[2:0];
            r_timer   <= '0;
            r_trigger <= w_go_oh;
          end
        end
        ST_TRIG: begin
          if (r_timer == TRIG_LAST) begin
            r_trigger <= '0;
            r_timer   <= '0;
            r_state   <= ST_WAIT_RISE;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        ST_WAIT_RISE: begin
          if (w_rise_ch) begin
            r_count <= '0;
            r_state <= ST_MEASURE;
          end else if (r_timer == RISE_LIMIT) begin
            for (int i = 0; i < N_CH; i++) if (w_ch_oh[i]) r_dist[i] <= '1;
            r_tmo   <= w_tmo_kept | w_ch_oh;
            r_timer <= '0;
            r_state <= ST_HOLDOFF;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        ST_MEASURE: begin
          if (w_fall_ch) begin
            for (int i = 0; i < N_CH; i++) if (w_ch_oh[i]) r_dist[i] <= r_count;
            r_valid <= w_valid_kept | w_ch_oh;
            r_tmo   <= w_tmo_kept & ~w_ch_oh;
            r_timer <= '0;
            r_state <= ST_HOLDOFF;
          end else if (r_count == ECHO_LIMIT) begin
            for (int i = 0; i < N_CH; i++) if (w_ch_oh[i]) r_dist[i] <= ECHO_LIMIT;
            r_tmo   <= w_tmo_kept | w_ch_oh;
            r_timer <= '0;
            r_state <= ST_HOLDOFF;
          end else if (w_level_ch && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_timer == HOLDOFF_LAST) begin
            if (w_go_pick[3]) begin
              r_state   <= ST_TRIG;
              r_ch      <= w_go_pick[2:0];
              r_timer   <= '0;
              r_trigger <= w_go_oh;
            end else begin
              r_state <= ST_IDLE;
              r_ch    <= 3'd0;
            end
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_dist
      assign w_dist_ext[gi] = 32'(r_dist[gi]);
    end
  endgenerate

  // Combinational read mux; unused addresses read zero
  always_comb begin
    rd_data = '0;
    if (addr == ADDR_CTRL) begin
      rd_data[CTRL_CONT_BIT]              = r_cont;
      rd_data[CTRL_MASK_LSB +: N_CH]      = r_mask;
    end else if (addr == ADDR_STATUS) begin
      rd_data[STAT_BUSY_BIT]              = (r_state != ST_IDLE);
      rd_data[STAT_CH_LSB +: 3]           = r_ch;
      rd_data[STAT_VALID_LSB +: N_CH]     = r_valid;
      rd_data[STAT_TMO_LSB +: N_CH]       = r_tmo;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (addr == ADDR_DIST_BASE + 5'(i)) rd_data = w_dist_ext[i];
      end
    end
  end

  assign trigger = r_trigger;

  // Reads have no side effects, so the read strobe is intentionally ignored.
  assign w_unused_bits = &{1'b0, read, wr_data, w_go_oh8, w_ch_oh8};

endmodule
